rr_arbiter_8: RTL and testbench



---
 rtl/rr_arbiter_8_if.sv | 15 +
 rtl/rr_arbiter_8.sv | 106 ++++++++++
 tb/tb_rr_arbiter_8.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the 8 requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, output done,
                  input gnt, input gnt_idx, input gnt_valid, input timeout);
  modport slave  (input req, input done,
                  output gnt, output gnt_idx, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a registered one-hot grant held until done/drop.
// Optional forced release after MAX_HOLD cycles under ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter_8_if.slave bus
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((2 ** HOLD_W) <= MAX_HOLD)) begin : g_bad_cfg
    $error("rr_arbiter_8: illegal MAX_HOLD/HOLD_W");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [7:0] gnt_q, gnt_nx;
  logic [2:0] idx_q, idx_nx;
  logic [2:0] ptr_q, ptr_nx;
  logic       to_q, to_nx;
  logic       found;
  logic [2:0] win, cand;
  logic       norm_rel, force_rel;

  // Scan ptr, ptr+1, ... ptr+7; 3-bit add gives the mod-8 wrap for free.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    cand  = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign norm_rel = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q;

  // Stays zero in IDLE, so it is already clear on grant entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hold_q <= '0;
    else if (state == GRANT) hold_q <= hold_q + 1'b1;
    else                     hold_q <= '0;
  end

  // A normal release in the limit cycle wins, so no timeout pulse then.
  assign force_rel = (hold_q == HOLD_W'(MAX_HOLD - 1)) & ~norm_rel;
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    idx_nx   = idx_q;
    ptr_nx   = ptr_q;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nx   = 8'd1 << win;
          idx_nx   = win;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (norm_rel || force_rel) begin
          gnt_nx   = 8'd0;
          ptr_nx   = idx_q + 3'd1;
          to_nx    = force_rel;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= 8'd0;
      idx_q <= 3'd0;
      ptr_q <= 3'd0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nx;
      gnt_q <= gnt_nx;
      idx_q <= idx_nx;
      ptr_q <= ptr_nx;
      to_q  <= to_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: expected winners are queued as requests are
// driven and popped on each rising gnt_valid.
module tb_rr_arbiter_8;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter_8_if bus();

  rr_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  logic vld_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Grant monitor: invariants every cycle, scoreboard pop on each new grant.
  always @(negedge clk) begin
    int e;
    chk("vld_eq_or", {31'd0, bus.gnt_valid}, {31'd0, |bus.gnt});
    chk("onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
`ifndef ARB_TIMEOUT_EN
    chk("timeout_tied", {31'd0, bus.timeout}, 32'd0);
`endif
    if (bus.gnt_valid && !vld_prev) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'd0, 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("sb_idx", {29'd0, bus.gnt_idx}, 32'(e));
        chk("sb_gnt", {24'd0, bus.gnt}, 32'd1 << e);
      end
    end
    vld_prev = bus.gnt_valid;
  end

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.gnt_valid) break;
    end
    chk(tag, {31'd0, bus.gnt_valid}, 32'd1);
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      wait_gnt("wait_serve");
      bus.done = 1'b1;
      @(negedge clk);
      bus.done = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int held;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    repeat (5) begin
      @(negedge clk);
      chk("rst_gnt", {24'd0, bus.gnt}, 32'd0);
      chk("rst_vld", {31'd0, bus.gnt_valid}, 32'd0);
      chk("rst_idx", {29'd0, bus.gnt_idx}, 32'd0);
    end

    // two requesters alternate
    exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(7);
    bus.req = 8'h81;
    serve(4);
    bus.req = 8'h00;
    drain("drain_81");

    // all requesters, pointer wraps 7 -> 0
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    bus.req = 8'hFF;
    serve(9);
    bus.req = 8'h00;
    drain("drain_ff");

    // release by request drop, pointer moves to 4
    exp_q.push_back(3);
    bus.req = 8'h08;
    wait_gnt("wait_3");
    bus.req = 8'h00;
    @(negedge clk);
    chk("drop_gnt", {24'd0, bus.gnt}, 32'd0);
    chk("drop_idx_keep", {29'd0, bus.gnt_idx}, 32'd3);
    exp_q.push_back(4);
    bus.req = 8'h18;
    serve(1);
    bus.req = 8'h00;
    drain("drain_18");

    // done and drop together give one release; done in IDLE is ignored
    exp_q.push_back(2);
    bus.req = 8'h04;
    wait_gnt("wait_2");
    bus.done = 1'b1;
    bus.req  = 8'h00;
    @(negedge clk);
    chk("dual_rel_gnt", {24'd0, bus.gnt}, 32'd0);
    chk("dual_rel_to", {31'd0, bus.timeout}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_gnt", {24'd0, bus.gnt}, 32'd0);
    end
    bus.done = 1'b0;
    drain("drain_dual");

    // request pending across release arbitrates with updated ptr (3 -> 4 -> 0)
    exp_q.push_back(4); exp_q.push_back(0);
    bus.req = 8'h11;
    serve(2);
    bus.req = 8'h00;
    drain("drain_11");

    // asynchronous reset mid-grant
    exp_q.push_back(5);
    bus.req = 8'h20;
    wait_gnt("wait_5");
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", {24'd0, bus.gnt}, 32'd0);
    chk("async_vld", {31'd0, bus.gnt_valid}, 32'd0);
    chk("async_idx", {29'd0, bus.gnt_idx}, 32'd0);
    @(negedge clk);
    chk("inrst_gnt", {24'd0, bus.gnt}, 32'd0);
    exp_q.push_back(5);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_regnt", {24'd0, bus.gnt}, 32'h20);
    @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    drain("drain_rst");

    // hold behaviour with requester 1 never finishing
`ifdef ARB_TIMEOUT_EN
    exp_q.push_back(1); exp_q.push_back(1);
    bus.req = 8'h02;
    wait_gnt("wait_1");
    held = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt == 8'h02) held++;
      else break;
    end
    chk("hold_len", 32'(held), 32'd4);
    chk("to_pulse", {31'd0, bus.timeout}, 32'd1);
    chk("to_gnt0", {24'd0, bus.gnt}, 32'd0);
    @(negedge clk);
    chk("to_clear", {31'd0, bus.timeout}, 32'd0);
    chk("to_regnt", {24'd0, bus.gnt}, 32'h02);
    bus.req = 8'h00;
    drain("drain_to");
`else
    exp_q.push_back(1);
    bus.req = 8'h02;
    wait_gnt("wait_1");
    held = 1;
    repeat (120) begin
      @(negedge clk);
      if (bus.gnt == 8'h02 && !bus.timeout) held++;
    end
    chk("hold_forever", 32'(held), 32'd121);
    bus.req = 8'h00;
    drain("drain_hold");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
